alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_rsp_slot.sv | 51 +++++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the arbiter's port identifier.
package alu_pkg;

    localparam int FN_W = 6;

    localparam logic [FN_W-1:0] FN_CMPEQ = 6'b000011;
    localparam logic [FN_W-1:0] FN_CMPLT = 6'b000101;
    localparam logic [FN_W-1:0] FN_CMPLE = 6'b000111;
    localparam logic [FN_W-1:0] FN_ADD   = 6'b010000;
    localparam logic [FN_W-1:0] FN_SUB   = 6'b010001;
    localparam logic [FN_W-1:0] FN_AND   = 6'b101000;
    localparam logic [FN_W-1:0] FN_OR    = 6'b101110;
    localparam logic [FN_W-1:0] FN_XOR   = 6'b100110;
    localparam logic [FN_W-1:0] FN_A     = 6'b101010;
    localparam logic [FN_W-1:0] FN_SHL   = 6'b110000;
    localparam logic [FN_W-1:0] FN_SHR   = 6'b110001;
    localparam logic [FN_W-1:0] FN_SRA   = 6'b110011;

    // Identifies a requester; also the encoding of the round-robin pointer.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response register for one arbiter port. Loads the ALU result
// on a grant and holds it until the consumer takes it.
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // The slot can take a new result when empty or when it drains this cycle.
    assign free      = ~valid_q | rsp_ready;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;

    // Next-state: a load wins over a drain so back-to-back results stream.
    always_comb begin
        // NOTE: defaults first so every path assigns each signal; no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only; the data register is reset too so rsp_data reads 0 out of reset.
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute
// stage (port 0) and the address/branch helper (port 1). Results return one
// cycle after acceptance through a per-port response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [5:0]       req0_fn,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [5:0]       req1_fn,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_data,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [5:0]       alu_fn,
    input  logic [W-1:0]     alu_out,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
);

    logic             free0, free1;
    logic             elig0, elig1;
    logic             gnt0, gnt1;
    port_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;

    // Eligibility and round-robin grant; nothing is accepted while in reset.
    always_comb begin
        elig0 = req0_valid & free0 & ~reset;
        elig1 = req1_valid & free1 & ~reset;
        gnt0  = elig0 & (~elig1 | (last_grant_q == PORT1));
        gnt1  = elig1 & (~elig0 | (last_grant_q == PORT0));
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Steer the granted port's operands to the ALU; port 0 when idle.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_fn = req0_fn;
        if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_fn = req1_fn;
        end
    end

    // Round-robin pointer and saturating grant counters.
    always_comb begin
        last_grant_d = last_grant_q;
        gnt0_cnt_d   = gnt0_cnt_q;
        gnt1_cnt_d   = gnt1_cnt_q;
        if (gnt0) begin
            last_grant_d = PORT0;
        end else if (gnt1) begin
            last_grant_d = PORT1;
        end
        if (gnt0 && (gnt0_cnt_q != '1)) begin
            gnt0_cnt_d = gnt0_cnt_q + CNT_W'(1);
        end
        if (gnt1 && (gnt1_cnt_q != '1)) begin
            gnt1_cnt_d = gnt1_cnt_q + CNT_W'(1);
        end
    end

    // Arbiter state; PORT1 at reset so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT1;
            gnt0_cnt_q   <= '0;
            gnt1_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt0_cnt_q   <= gnt0_cnt_d;
            gnt1_cnt_q   <= gnt1_cnt_d;
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;

    alu_rsp_slot #(.W(W)) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (gnt0),
        .load_data (alu_out),
        .rsp_ready (rsp0_ready),
        .rsp_valid (rsp0_valid),
        .rsp_data  (rsp0_data),
        .free      (free0)
    );

    alu_rsp_slot #(.W(W)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (gnt1),
        .load_data (alu_out),
        .rsp_ready (rsp1_ready),
        .rsp_valid (rsp1_valid),
        .rsp_data  (rsp1_data),
        .free      (free1)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU, a per-port
// response scoreboard, a cycle table and hand-written corner sequences.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    typedef struct {
        logic         v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   f;
    } req_t;

    typedef struct {
        logic         rst;
        req_t         q0;
        req_t         q1;
        logic         r0, r1;
        logic         e_rdy0, e_rdy1;
        logic         e_rv0, e_rv1;
        int           e_c0, e_c1;
        logic         chk_d0, chk_d1;
        logic [W-1:0] e_d0, e_d1;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [5:0]       req0_fn, req1_fn;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]     rsp0_data, rsp1_data;
    logic [W-1:0]     alu_a, alu_b, alu_out;
    logic [5:0]       alu_fn;
    logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    req_t rq_none  = '{1'b0, 32'd0, 32'd0, 6'd0};
    req_t rq_sub   = '{1'b1, 32'd10, 32'd4, FN_SUB};
    req_t rq_xor   = '{1'b1, 32'hF0, 32'hFF, FN_XOR};
    req_t rq_add12 = '{1'b1, 32'd1, 32'd2, FN_ADD};
    req_t rq_and   = '{1'b1, 32'hFF, 32'h0F, FN_AND};

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_fn    (req0_fn),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_fn    (req1_fn),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fn     (alu_fn),
        .alu_out    (alu_out),
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
    );

    // Reference ALU behaviour, used both as the shared ALU and for predictions.
    function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [5:0] fn);
        case (fn)
            FN_CMPEQ: alu_f = {31'd0, a == b};
            FN_CMPLT: alu_f = {31'd0, $signed(a) < $signed(b)};
            FN_CMPLE: alu_f = {31'd0, $signed(a) <= $signed(b)};
            FN_ADD:   alu_f = a + b;
            FN_SUB:   alu_f = a - b;
            FN_AND:   alu_f = a & b;
            FN_OR:    alu_f = a | b;
            FN_XOR:   alu_f = a ^ b;
            FN_A:     alu_f = a;
            FN_SHL:   alu_f = a << b[4:0];
            FN_SHR:   alu_f = a >> b[4:0];
            FN_SRA:   alu_f = $signed(a) >>> b[4:0];
            default:  alu_f = '0;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_a, alu_b, alu_fn);

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: predict on acceptance, compare when a response is consumed.
    always @(negedge clk) begin
        if (reset) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                if (exp0_q.size() == 0) check("sb0 unexpected rsp", 32'(rsp0_valid), 32'd0);
                else check("sb0 data", rsp0_data, exp0_q.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) check("sb1 unexpected rsp", 32'(rsp1_valid), 32'd0);
                else check("sb1 data", rsp1_data, exp1_q.pop_front());
            end
            if (req0_valid && req0_ready) exp0_q.push_back(alu_f(req0_a, req0_b, req0_fn));
            if (req1_valid && req1_ready) exp1_q.push_back(alu_f(req1_a, req1_b, req1_fn));
            if (req0_valid && req1_valid) check("one ready", 32'(req0_ready & req1_ready), 32'd0);
        end
    end

    // Requester-side rule: a pending request keeps valid and operands stable.
    logic         hold0, hold1;
    req_t         sav0, sav1;
    initial begin
        hold0 = 1'b0;
        hold1 = 1'b0;
    end
    always @(posedge clk) begin
        if (hold0) assert (req0_valid && req0_a == sav0.a && req0_b == sav0.b && req0_fn == sav0.f)
            else $error("request 0 changed before acceptance");
        if (hold1) assert (req1_valid && req1_a == sav1.a && req1_b == sav1.b && req1_fn == sav1.f)
            else $error("request 1 changed before acceptance");
        hold0 <= req0_valid & ~req0_ready;
        hold1 <= req1_valid & ~req1_ready;
        sav0  <= '{req0_valid, req0_a, req0_b, req0_fn};
        sav1  <= '{req1_valid, req1_a, req1_b, req1_fn};
    end

    task automatic drive(input req_t q0, input req_t q1, input bit r0, input bit r1);
        req0_valid = q0.v;
        req0_a     = q0.a;
        req0_b     = q0.b;
        req0_fn    = q0.f;
        req1_valid = q1.v;
        req1_a     = q1.a;
        req1_b     = q1.b;
        req1_fn    = q1.f;
        rsp0_ready = r0;
        rsp1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int rst, req_t q0, req_t q1, int r0, int r1,
                                int erdy0, int erdy1, int erv0, int erv1, int ec0, int ec1,
                                int cd0, int ed0, int cd1, int ed1);
        vec_t v;
        v.rst    = (rst != 0);
        v.q0     = q0;
        v.q1     = q1;
        v.r0     = (r0 != 0);
        v.r1     = (r1 != 0);
        v.e_rdy0 = (erdy0 != 0);
        v.e_rdy1 = (erdy1 != 0);
        v.e_rv0  = (erv0 != 0);
        v.e_rv1  = (erv1 != 0);
        v.e_c0   = ec0;
        v.e_c1   = ec1;
        v.chk_d0 = (cd0 != 0);
        v.e_d0   = ed0;
        v.chk_d1 = (cd1 != 0);
        v.e_d1   = ed1;
        return v;
    endfunction

    vec_t vecs[$];
    logic [5:0] fn_list[12];

    initial begin
        fn_list = '{FN_CMPEQ, FN_CMPLT, FN_CMPLE, FN_ADD, FN_SUB, FN_AND,
                    FN_OR, FN_XOR, FN_A, FN_SHL, FN_SHR, FN_SRA};

        //                rst q0        q1       r0 r1 rdy0 rdy1 rv0 rv1 c0 c1 cd0 d0 cd1 d1
        vecs.push_back(mk(1, rq_none,  rq_none, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, rq_none,  rq_none, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // both ports continuously eligible: alternating grants starting at port 0
        vecs.push_back(mk(0, rq_sub,   rq_xor,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, rq_sub,   rq_xor,  1, 1, 0, 1, 1, 0, 1, 0, 1, 6, 0, 0));
        vecs.push_back(mk(0, rq_sub,   rq_xor,  1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 'h0F));
        vecs.push_back(mk(0, rq_sub,   rq_xor,  1, 1, 0, 1, 1, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, rq_sub,   rq_none, 1, 1, 1, 0, 0, 1, 2, 2, 0, 0, 0, 0));
        // port 0 back-pressured: port 1 streams, port 0 data held
        vecs.push_back(mk(0, rq_add12, rq_and,  0, 1, 0, 1, 1, 0, 3, 2, 1, 6, 0, 0));
        vecs.push_back(mk(0, rq_add12, rq_and,  0, 1, 0, 1, 1, 1, 3, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, rq_add12, rq_and,  0, 1, 0, 1, 1, 1, 3, 4, 0, 0, 0, 0));
        // consumer releases: port 0 granted in that same cycle
        vecs.push_back(mk(0, rq_add12, rq_and,  1, 1, 1, 0, 1, 1, 3, 5, 1, 6, 0, 0));
        vecs.push_back(mk(0, rq_none,  rq_and,  1, 1, 0, 1, 1, 0, 4, 5, 1, 3, 0, 0));
        vecs.push_back(mk(0, rq_none,  rq_none, 1, 1, 0, 0, 0, 1, 4, 6, 0, 0, 1, 'h0F));
        vecs.push_back(mk(0, rq_none,  rq_none, 1, 1, 0, 0, 0, 0, 4, 6, 0, 0, 0, 0));

        reset = 1'b1;
        drive(rq_none, rq_none, 1'b0, 1'b0);
        tick();
        tick();

        // reset state
        reset = 1'b0;
        drive(rq_none, rq_none, 1'b1, 1'b1);
        @(negedge clk);
        check("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("reset rsp0_data", rsp0_data, 32'd0);
        check("reset rsp1_data", rsp1_data, 32'd0);
        check("reset gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        check("reset gnt1_cnt", 32'(gnt1_cnt), 32'd0);
        tick();

        // single port 0 add
        drive('{1'b1, 32'd5, 32'd3, FN_ADD}, rq_none, 1'b1, 1'b1);
        @(negedge clk);
        check("add req0_ready", 32'(req0_ready), 32'd1);
        check("add alu_fn", 32'(alu_fn), 32'(FN_ADD));
        tick();
        drive(rq_none, rq_none, 1'b1, 1'b1);
        @(negedge clk);
        check("add rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("add rsp0_data", rsp0_data, 32'd8);
        check("add gnt0_cnt", 32'(gnt0_cnt), 32'd1);
        tick();

        // cycle table
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].q0, vecs[i].q1, vecs[i].r0, vecs[i].r1);
            @(negedge clk);
            check($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
            check($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
            check($sformatf("vec%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].e_rv0));
            check($sformatf("vec%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].e_rv1));
            check($sformatf("vec%0d gnt0_cnt", i), 32'(gnt0_cnt), 32'(vecs[i].e_c0));
            check($sformatf("vec%0d gnt1_cnt", i), 32'(gnt1_cnt), 32'(vecs[i].e_c1));
            if (vecs[i].chk_d0) check($sformatf("vec%0d rsp0_data", i), rsp0_data, vecs[i].e_d0);
            if (vecs[i].chk_d1) check($sformatf("vec%0d rsp1_data", i), rsp1_data, vecs[i].e_d1);
            tick();
        end
        reset = 1'b0;

        // same-cycle drain on port 1
        drive(rq_none, '{1'b1, 32'd100, 32'd1, FN_ADD}, 1'b1, 1'b1);
        @(negedge clk);
        check("drain first req1_ready", 32'(req1_ready), 32'd1);
        tick();
        drive(rq_none, '{1'b1, 32'd100, 32'd1, FN_SUB}, 1'b1, 1'b1);
        @(negedge clk);
        check("drain req1_ready", 32'(req1_ready), 32'd1);
        check("drain old rsp1_data", rsp1_data, 32'd101);
        tick();
        drive(rq_none, rq_none, 1'b1, 1'b1);
        @(negedge clk);
        check("drain rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("drain new rsp1_data", rsp1_data, 32'd99);
        tick();
        @(negedge clk);
        check("drain empty rsp1_valid", 32'(rsp1_valid), 32'd0);
        tick();

        // reset with a pending port 0 response and a port 1 request
        drive('{1'b1, 32'd7, 32'd7, FN_ADD}, rq_none, 1'b0, 1'b1);
        @(negedge clk);
        check("rst pre req0_ready", 32'(req0_ready), 32'd1);
        tick();
        reset = 1'b1;
        drive(rq_none, '{1'b1, 32'h30, 32'h03, FN_OR}, 1'b0, 1'b1);
        @(negedge clk);
        check("rst req1_ready", 32'(req1_ready), 32'd0);
        tick();
        reset = 1'b0;
        drive('{1'b1, 32'd3, 32'd5, FN_XOR}, '{1'b1, 32'h30, 32'h03, FN_OR}, 1'b1, 1'b1);
        @(negedge clk);
        check("rst dropped rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst rsp0_data", rsp0_data, 32'd0);
        check("rst gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        check("rst gnt1_cnt", 32'(gnt1_cnt), 32'd0);
        check("rst tie req0_ready", 32'(req0_ready), 32'd1);
        check("rst tie req1_ready", 32'(req1_ready), 32'd0);
        tick();
        drive(rq_none, '{1'b1, 32'h30, 32'h03, FN_OR}, 1'b1, 1'b1);
        @(negedge clk);
        check("rst next req1_ready", 32'(req1_ready), 32'd1);
        check("rst xor rsp0_data", rsp0_data, 32'd6);
        tick();
        drive(rq_none, rq_none, 1'b1, 1'b1);
        tick();
        tick();

        // counter saturation with random port 0 traffic
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive('{1'b1, $urandom, $urandom, fn_list[$urandom_range(0, 11)]}, rq_none, 1'b1, 1'b1);
            @(negedge clk);
            check($sformatf("sat%0d req0_ready", k), 32'(req0_ready), 32'd1);
            check($sformatf("sat%0d gnt0_cnt", k), 32'(gnt0_cnt), 32'((k > 15) ? 15 : k));
            tick();
        end
        drive(rq_none, rq_none, 1'b1, 1'b1);
        @(negedge clk);
        check("sat hold gnt0_cnt", 32'(gnt0_cnt), 32'd15);
        tick();
        tick();

        check("sb0 outstanding", 32'(exp0_q.size()), 32'd0);
        check("sb1 outstanding", 32'(exp1_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
